// File: rtl/seri_toplayici_denetleyici.sv
// Bit-serial N-bit adder: one shared full adder processes one bit pair per clock,
// LSB first, with the ripple carry held in a flip-flop between cycles.

module tamtoplayici (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one bit pair per cycle through the full adder, N cycles
// DONE  | one-cycle completion pulse; sum/cout valid from here on
module seri_toplayici_denetleyici #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  s_sh;
    logic          c;
    logic [CW-1:0] cnt;
    logic          fa_s;
    logic          fa_c;
    logic          s_sh_lsb_unused;

    tamtoplayici u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (c),
        .S    (fa_s),
        .Cout (fa_c)
    );

    // The final sum bit goes straight into sum, so the oldest partial bit is never read.
    assign s_sh_lsb_unused = s_sh[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_sh <= {fa_s, s_sh[N-1:1]};
                    a_sh <= {1'b0, a_sh[N-1:1]};
                    b_sh <= {1'b0, b_sh[N-1:1]};
                    c    <= fa_c;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        sum   <= {fa_s, s_sh[N-1:1]};
                        cout  <= fa_c;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from the state register, so both are glitch-free.
    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_seri_toplayici_denetleyici.sv
// Bench for the bit-serial adder: N=8 vectors, random ops, corner sequences, N=2 exhaustive.

module tb_seri_toplayici_denetleyici;
    logic       clk;
    logic       rst;
    logic       start8, cin8, cout8, busy8, done8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, cout2, busy2, done2;
    logic [1:0] a2, b2, sum2;

    int total = 0;
    int bad   = 0;
    logic [7:0] prev_sum;
    logic       prev_cout;

    seri_toplayici_denetleyici #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
    );

    seri_toplayici_denetleyici #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .sum(sum2), .cout(cout2), .busy(busy2), .done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // One full N=8 operation; the reference is plain (N+1)-bit arithmetic.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        logic [8:0] r;
        r = 9'(ia) + 9'(ib) + 9'(ic);
        @(negedge clk);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start8 = 1'b0;
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            chk("run_busy_done", {30'd0, busy8, done8}, 32'b10);
            chk("run_hold", {23'd0, cout8, sum8}, {23'd0, prev_cout, prev_sum});
        end
        @(negedge clk);
        chk("done_cycle", {30'd0, busy8, done8}, 32'b01);
        chk("result", {23'd0, cout8, sum8}, {23'd0, r});
        prev_sum  = r[7:0];
        prev_cout = r[8];
        @(negedge clk);
        chk("back_idle", {30'd0, busy8, done8}, 32'b00);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};

        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
        prev_sum = 8'h00; prev_cout = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset8", {20'd0, busy8, done8, cout8, sum8}, 32'd0);
        chk("reset2", {26'd0, busy2, done2, cout2, sum2}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin);
            chk("vector", {23'd0, cout8, sum8}, {23'd0, vecs[i].ec, vecs[i].es});
        end

        // start pulses in RUN and in DONE must be ignored; operands captured at accept
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            start8 = (cyc == 3 || cyc == 9);
            if (cyc == 1) begin
                a8 = 8'hFF; b8 = 8'hFF;
            end
            chk("ign_busy", {31'd0, busy8}, {31'd0, (cyc >= 1 && cyc <= 8)});
            chk("ign_done", {31'd0, done8}, {31'd0, (cyc == 9)});
            if (cyc == 9) chk("ign_sum", {23'd0, cout8, sum8}, 32'h046);
        end
        start8 = 1'b0;
        prev_sum = 8'h46; prev_cout = 1'b0;

        // reset mid-run aborts and clears the held result
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h22; cin8 = 1'b1; start8 = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start8 = 1'b0;
            chk("pre_rst_busy", {31'd0, busy8}, 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst", {20'd0, busy8, done8, cout8, sum8}, 32'd0);
        rst = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            chk("post_rst_quiet", {30'd0, busy8, done8}, 32'd0);
        end
        prev_sum = 8'h00; prev_cout = 1'b0;
        op8(8'h81, 8'h7E, 1'b1);

        for (int i = 0; i < 25; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom));

        // N=2 exhaustive with start held high: one result every 4 cycles
        @(negedge clk);
        {a2, b2, cin2} = 5'd0;
        start2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            logic [2:0] r2;
            v  = 5'(i);
            r2 = 3'(v[4:3]) + 3'(v[2:1]) + 3'(v[0]);
            @(negedge clk);
            {a2, b2, cin2} = 5'(i + 1);
            chk("n2_c1", {30'd0, busy2, done2}, 32'b10);
            @(negedge clk);
            chk("n2_c2", {30'd0, busy2, done2}, 32'b10);
            @(negedge clk);
            chk("n2_done", {30'd0, busy2, done2}, 32'b01);
            chk("n2_result", {29'd0, cout2, sum2}, {29'd0, r2});
            @(negedge clk);
            if (i == 31) start2 = 1'b0;
            chk("n2_idle", {30'd0, busy2, done2}, 32'b00);
        end
        repeat (3) begin
            @(negedge clk);
            chk("n2_stop", {30'd0, busy2, done2}, 32'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seri_toplayici_denetleyici.md
# seri_toplayici_denetleyici

Bit-serial N-bit adder controller built around the team's existing one-bit full adder `tamtoplayici` (ports A, B, Cin, S, Cout), instantiated exactly once. It accepts two N-bit operands plus a carry-in with a start/busy/done handshake. It feeds the full adder one bit pair per clock, LSB first, holding the ripple carry in a flip-flop between cycles, and presents a registered N-bit sum and carry-out. It lets lab designs share a single full adder for multi-bit additions instead of instantiating N copies.

## Interface
- `N`, default 8: operand/sum width in bits; legal range N >= 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  N  operand A; captured on the accepted start edge.
- `b`  in  N  operand B; captured on the accepted start edge.
- `cin`  in  1  carry-in; captured on the accepted start edge.
- `sum`  out  N  registered result; holds its value until the next completion.
- `cout`  out  1  registered final carry-out; holds like `sum`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse in DONE; `sum`/`cout` are valid from this cycle on.

## Operation
- Internal state: FSM {IDLE, RUN, DONE}, operand shift registers `a_sh`/`b_sh` (N bits), carry flip-flop `c`, partial-sum shift register `s_sh` (N bits), bit counter `cnt` ($clog2(N) bits).
- Full adder connections: A = `a_sh[0]`, B = `b_sh[0]`, Cin = `c`.
- IDLE:
  - If `start`=1: `a_sh`<=`a`, `b_sh`<=`b`, `c`<=`cin`, `cnt`<=0, go to RUN.
  - Otherwise remain in IDLE.
- RUN, every cycle:
  - `s_sh` <= {S, `s_sh[N-1:1]`}.
  - `a_sh` and `b_sh` shift right by one.
  - `c` <= Cout.
  - `cnt` <= `cnt`+1.
  - When `cnt`==N-1: load `sum` <= {S, `s_sh[N-1:1]`} and `cout` <= Cout, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then unconditionally go to IDLE. `start` is ignored in DONE.
- `start` is ignored in RUN and DONE. There is no queuing, and the ignored request has no side effect.
- `a`, `b`, `cin` may change freely after the accepted start edge without affecting the result.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin` modulo 2^(N+1). Exact, never saturating.
- `sum`/`cout` change only on the RUN→DONE edge and at reset. During a new RUN they still show the previous result.

## Timing
- Reset values: state IDLE; `sum`=0, `cout`=0, `busy`=0, `done`=0; internal registers 0.
- `rst` has priority over every other input in every state.
  - Reset mid-RUN aborts the operation: no `done` pulse, and `sum`/`cout` are cleared to 0.
- Let the accepting edge (start=1 in IDLE) be edge 0:
  - `busy` is high during cycles 1..N.
  - `done` is high during cycle N+1.
  - The FSM is back in IDLE in cycle N+2.
- Latency from start edge to `done` is N+1 cycles. Back-to-back throughput is one addition per N+2 cycles.
- `busy` and `done` are never high in the same cycle. `done` is decoded from state, so it is glitch-free and registered-equivalent.
- `start` held high continuously: a new operation is accepted in every IDLE cycle, i.e. at edges 0, N+2, 2(N+2), ...

## Test plan
- N=8, a=0x00, b=0x00, cin=0 → `done` in cycle 9, `sum`=0x00, `cout`=0; `busy` high in cycles 1..8 only.
- N=8, a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1. Then a=0xA5, b=0x5A, cin=1 → `sum`=0x00, `cout`=1; `sum` still reads 0x00 from the first result during the second run.
- N=8, a=0xFF, b=0xFF, cin=1 → `sum`=0xFF, `cout`=1. Also a=0x3C, b=0x0F, cin=0 → `sum`=0x4B, `cout`=0.
- Start ignored and operands captured:
  - Start an operation with a=0x12, b=0x34.
  - Change a/b to 0xFF/0xFF and pulse `start` at cycles 3 and 9 (the DONE cycle).
  - Required: a single `done` in cycle 9, `sum`=0x46, no second operation.
- Reset mid-operation: assert `rst` in cycle 4 of a run → the next cycle shows IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, and no `done` follows. A fresh start afterwards gives a correct result.
- N=2, exhaustive over all a, b, cin (32 cases) with `start` held high → every result equals a+b+cin and `done` recurs every 4 cycles.
